// File: rtl/pipe_pkg.sv
// Shared types and constants for the inter-stage pipeline skid buffers.
// Bundle sizes describe the word carried across each stage boundary.
package pipe_pkg;

    localparam int unsigned W_DEFAULT = 16;

    localparam int unsigned F_D = 2 * W_DEFAULT;
    localparam int unsigned D_E = 18 + 2 * W_DEFAULT;
    localparam int unsigned E_M = 2 * W_DEFAULT;
    localparam int unsigned M_W = 18 + 3 * W_DEFAULT;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } pipe_state_t;

endpackage

// File: rtl/pipe_data_reg.sv
// W-bit data register with synchronous reset to NOP_VALUE and load enable.
module pipe_data_reg #(
    parameter int unsigned    W         = 16,
    parameter logic [W-1:0]   NOP_VALUE = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [W-1:0]  d,
    output logic [W-1:0]  q
);

    always_ff @(posedge clk) begin
        if (rst)
            q <= NOP_VALUE;
        else if (load)
            q <= d;
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// Two-entry valid/ready pipeline stage buffer with flush and bubble output.
// Optional stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int unsigned  W         = W_DEFAULT,
    parameter logic [W-1:0] NOP_VALUE = '0,
    parameter int unsigned  CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [1:0]       level,
    output logic [CNT_W-1:0] stall_cnt
);

    pipe_state_t    state, state_nxt;
    logic           accept, take;
    logic           load_main, load_skid, main_from_skid;
    logic [W-1:0]   main_q, skid_q, main_d;

    assign accept = in_valid & in_ready;
    assign take   = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst)
            state <= EMPTY;
        else
            state <= state_nxt;
    end

    // Flush wins over every transition; register loads are suppressed so
    // held beats are simply abandoned and the bubble is shown.
    always_comb begin
        state_nxt      = state;
        load_main      = 1'b0;
        load_skid      = 1'b0;
        main_from_skid = 1'b0;
        if (flush) begin
            state_nxt = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        state_nxt = FULL;
                        load_main = 1'b1;
                    end
                end
                FULL: begin
                    if (accept && take) begin
                        load_main = 1'b1;
                    end else if (accept) begin
                        state_nxt = SKID;
                        load_skid = 1'b1;
                    end else if (take) begin
                        state_nxt = EMPTY;
                    end
                end
                SKID: begin
                    if (take) begin
                        state_nxt      = FULL;
                        load_main      = 1'b1;
                        main_from_skid = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready  = !rst && (state != SKID);
        out_valid = (state != EMPTY);
        out_data  = out_valid ? main_q : NOP_VALUE;
        level     = state;
    end

    assign main_d = main_from_skid ? skid_q : in_data;

    pipe_data_reg #(.W(W), .NOP_VALUE(NOP_VALUE)) u_main (
        .clk  (clk),
        .rst  (rst),
        .load (load_main),
        .d    (main_d),
        .q    (main_q)
    );

    pipe_data_reg #(.W(W), .NOP_VALUE(NOP_VALUE)) u_skid (
        .clk  (clk),
        .rst  (rst),
        .load (load_skid),
        .d    (in_data),
        .q    (skid_q)
    );

`ifdef PIPE_STALL_CNT_EN
    logic [CNT_W-1:0] cnt_q;

    // Saturating; flush deliberately leaves the count alone.
    always_ff @(posedge clk) begin
        if (rst)
            cnt_q <= '0;
        else if (out_valid && !out_ready && (cnt_q != '1))
            cnt_q <= cnt_q + 1'b1;
    end

    assign stall_cnt = cnt_q;
`else
    assign stall_cnt = '0;
`endif

endmodule
